// File: rtl/instr_encoder.sv
// instr_encoder
//   Streaming RISC-V instruction assembler. Takes decoded fields (format,
//   opcode, registers, funct3, 32-bit immediate) and scatters the immediate
//   into the format-specific bit positions of a 32-bit instruction word.
//   Two register stages with a valid/ready stream on both sides:
//     stage 1 : captured fields + encodability error
//     stage 2 : assembled instruction word + out_err
//
//   Build option:
//     INSTR_ENC_RANGE_CHECK_EN defined   -> immediates that do not fit the
//                                           format raise out_err.
//     INSTR_ENC_RANGE_CHECK_EN undefined -> out-of-field immediate bits are
//                                           dropped; out_err only marks
//                                           illegal type codes.
//
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     in_valid / in_ready        input field stream handshake
//     in_type                    000 I, 001 S, 010 B, 011 J, 100 U, else illegal
//     in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm   decoded fields
//     out_valid / out_ready      output word stream handshake
//     out_instr, out_err         assembled word, not-encodable flag
//     enc_count                  error-free words handed off (wraps)
//     err_sticky                 any errored word handed off since reset
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic             err_sticky
);

  localparam logic [2:0] T_I = 3'd0;
  localparam logic [2:0] T_S = 3'd1;
  localparam logic [2:0] T_B = 3'd2;
  localparam logic [2:0] T_J = 3'd3;
  localparam logic [2:0] T_U = 3'd4;

  typedef struct packed {
    logic [2:0]  typ;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        err;
  } s1_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q, s2_instr_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  logic s1_adv, s2_adv;
  logic in_err;
  logic [31:0] asm_word;

  // ---------------------------------------------------------------------
  // Handshake: a stage may load when it is empty or its content leaves.
  // in_ready therefore sees out_ready combinationally; the data path
  // itself is fully registered.
  // ---------------------------------------------------------------------
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  // ---------------------------------------------------------------------
  // Encodability of the incoming fields
  // ---------------------------------------------------------------------
  always_comb begin
    in_err = 1'b0;
    case (in_type)
`ifdef INSTR_ENC_RANGE_CHECK_EN
      // Sign bits above the field must all equal the field's top bit.
      T_I, T_S: in_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      // Branch/jump offsets are halfword aligned; bit 0 is not encoded.
      T_B:      in_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      T_J:      in_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      T_U:      in_err = |in_imm[11:0];
`else
      T_I, T_S, T_B, T_J, T_U: in_err = 1'b0;
`endif
      default:  in_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage 1 capture
  // ---------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.typ    = in_type;
        s1_d.opcode = in_opcode;
        s1_d.rd     = in_rd;
        s1_d.rs1    = in_rs1;
        s1_d.rs2    = in_rs2;
        s1_d.funct3 = in_funct3;
        s1_d.imm    = in_imm;
        s1_d.err    = in_err;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Immediate scatter from the stage-1 fields
  // ---------------------------------------------------------------------
  always_comb begin
    asm_word = 32'd0;
    case (s1_q.typ)
      T_I: asm_word = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd,
                       s1_q.opcode};
      T_S: asm_word = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                       s1_q.imm[4:0], s1_q.opcode};
      T_B: asm_word = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                       s1_q.funct3, s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
      T_J: asm_word = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                       s1_q.imm[19:12], s1_q.rd, s1_q.opcode};
      T_U: asm_word = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
      // Illegal type codes emit an all-zero word.
      default: asm_word = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage 2 and handoff bookkeeping
  // ---------------------------------------------------------------------
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = asm_word;
        s2_err_d   = s1_q.err;
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (s2_valid_q && out_ready) begin
      if (s2_err_q) sticky_d = 1'b1;
      else          cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'd0;
      s2_err_q   <= 1'b0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_instr  = s2_instr_q;
  assign out_err    = s2_err_q;
  assign enc_count  = cnt_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed literal checks plus a randomized
// stream scored against a behavioural queue model of the two-stage pipe.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_type = 3'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic        err_sticky;

  instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          tag;
  } ent_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          pops = 0;
  ent_t        q[$];
  logic [31:0] poplog[$];
  logic [15:0] m_cnt = 16'd0;
  logic        m_sticky = 1'b0;
  logic [31:0] last_instr;
  logic        last_err;
  logic        last_fin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Does the immediate fit the format's field?
  function automatic bit in_range(input logic [2:0] t, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (t)
      3'd0, 3'd1: return s >= -2048 && s <= 2047;
      3'd2:       return s >= -4096 && s <= 4095 && imm[0] == 1'b0;
      3'd3:       return s >= -(1 << 20) && s < (1 << 20) && imm[0] == 1'b0;
      3'd4:       return (imm & 32'hFFF) == 32'd0;
      default:    return 1'b0;
    endcase
  endfunction

  // Reference encoding built with shifts and masks: returns {err, word}.
  function automatic logic [32:0] model(input logic [2:0] t, input logic [31:0] op,
      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] f3, input logic [31:0] u);
    logic [31:0] w;
    logic        err;
    err = 1'b0;
    case (t)
      3'd0: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | ((u & 32'h1F) << 7) | op;
      3'd2: w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
              | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
              | (((u >> 11) & 32'h1) << 7) | op;
      3'd3: w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
              | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
              | (rd << 7) | op;
      3'd4: w = (u & 32'hFFFFF000) | (rd << 7) | op;
      default: begin w = 32'd0; err = 1'b1; end
    endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
    if (t <= 3'd4 && !in_range(t, u)) err = 1'b1;
`endif
    return {err, w};
  endfunction

  // One clock of activity: check outputs against the model at the falling
  // edge, drive the next inputs, then advance the model by the handshakes
  // that the next rising edge will perform.
  task automatic step(input logic v, input logic [2:0] t, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [31:0] imm, input logic ordy);
    logic        ev, erdy, fout;
    logic [32:0] m;
    @(negedge clk);
    cyc++;
    // A word is visible once two rising edges have passed since its accept.
    ev = (q.size() > 0) && (cyc - q[0].tag >= 2);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_err", out_err, q[0].err);
    end
    chk("enc_count", enc_count, m_cnt);
    chk("err_sticky", err_sticky, m_sticky);
    in_valid = v; in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_imm = imm; out_ready = ordy;
    #1;
    erdy = (q.size() < 2) || ordy;
    chk("in_ready", in_ready, erdy);
    last_fin = v && erdy;
    fout = ev && ordy;
    if (fout) begin
      last_instr = q[0].instr;
      last_err   = q[0].err;
      poplog.push_back(q[0].instr);
      pops++;
      if (q[0].err) m_sticky = 1'b1;
      else          m_cnt = m_cnt + 16'd1;
      void'(q.pop_front());
    end
    if (last_fin) begin
      m = model(t, op, rd, rs1, rs2, f3, imm);
      q.push_back('{instr: m[31:0], err: m[32], tag: cyc});
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, ordy);
  endtask

  // Send one word into an empty pipe and wait (bounded) for its handoff,
  // then one more cycle so the counters reflect it.
  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [31:0] imm);
    int p0;
    p0 = pops;
    step(1'b1, t, op, rd, rs1, rs2, f3, imm, 1'b1);
    for (int k = 0; k < 8 && pops == p0; k++) idle(1'b1);
    if (pops == p0) chk("send timeout", 32'd0, 32'd1);
    idle(1'b1);
  endtask

  initial begin
    int idx, p0, r;
    logic [2:0]  t;
    logic [31:0] imm;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_instr", out_instr, 0);
    chk("rst out_err", out_err, 0);
    chk("rst enc_count", enc_count, 0);
    chk("rst err_sticky", err_sticky, 0);
    chk("rst in_ready", in_ready, 1);
    rst_n = 1'b1;

    // ---- directed format examples ----
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF);
    chk("I word", last_instr, 32'hFFF00093);
    chk("I err", last_err, 0);
    chk("I count", enc_count, 1);
    send(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8);
    chk("S word", last_instr, 32'h0020A423);
    send(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC);
    chk("B word", last_instr, 32'hFE000EE3);
    send(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
    chk("J word", last_instr, 32'h001000EF);
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
    chk("U word", last_instr, 32'h123452B7);
    chk("count after 5", enc_count, 5);

    // ---- out-of-range immediates ----
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    chk("I range err", last_err, 1);
    chk("I range sticky", err_sticky, 1);
    chk("I range count", enc_count, 5);
`else
    chk("I trunc word", last_instr, 32'h80000093);
    chk("I trunc err", last_err, 0);
`endif
    send(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    chk("B odd err", last_err, 1);
    chk("B odd count", enc_count, 5);
`else
    chk("B odd word", last_instr, 32'h00000163);
    chk("B odd err", last_err, 0);
`endif
    send(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 32'hFFFFFFFF);
    chk("type7 word", last_instr, 32'd0);
    chk("type7 err", last_err, 1);
    chk("type7 sticky", err_sticky, 1);

    // ---- backpressure: 3 words offered with out_ready held low ----
    idx = 0;
    p0 = pops;
    poplog.delete();
    for (int k = 0; k < 20; k++) begin
      step(idx < 3, 3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 32'((idx + 1) << 12), k >= 4);
      if (k == 2) chk("bp in_ready full", in_ready, 0);
      if (last_fin) idx++;
    end
    chk("bp accepted", idx, 3);
    chk("bp emerged", pops - p0, 3);
    if (poplog.size() == 3) begin
      chk("bp order 0", poplog[0], 32'h00001037);
      chk("bp order 1", poplog[1], 32'h00002037);
      chk("bp order 2", poplog[2], 32'h00003037);
    end else chk("bp poplog size", poplog.size(), 3);

    // ---- randomized stream ----
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 9);
      t = (r < 8) ? 3'(r % 5) : 3'(5 + r % 3);
      case ($urandom_range(0, 2))
        0: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
        1: imm = $urandom & 32'hFFFFF000;
        default: imm = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, t, 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom), imm, $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 10 && q.size() > 0; k++) idle(1'b1);
    chk("random drained", q.size(), 0);

    // ---- run enc_count up to all-ones, then wrap ----
    for (int k = 0; k < 70000 && (int'(m_cnt) + q.size() < 65535); k++)
      step(1'b1, 3'd0, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'd4, 1'b1);
    for (int k = 0; k < 10 && q.size() > 0; k++) idle(1'b1);
    idle(1'b1);
    chk("count all-ones", enc_count, 32'hFFFF);
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    chk("count wrap", enc_count, 0);
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    chk("count after wrap", enc_count, 1);

    // ---- asynchronous reset with two words in flight ----
    step(1'b1, 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h5000, 1'b0);
    step(1'b1, 3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 32'h6000, 1'b0);
    idle(1'b0);
    chk("inflight valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst enc_count", enc_count, 0);
    chk("arst err_sticky", err_sticky, 0);
    chk("arst in_ready", in_ready, 1);
    q.delete();
    m_cnt = 16'd0;
    m_sticky = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
